// File: rtl/packet_sram_responder_pkg.sv
// -----------------------------------------------------------------------------
// packet_sram_responder_pkg
// Shared definitions for the packet SRAM responder and its integration wrapper:
//   PKT_SRAM_DEPTH    default number of packet slots
//   PKT_SRAM_ADDR_W   address width matching PKT_SRAM_DEPTH
//   pkt_sram_state_t  responder FSM states (IDLE, LOAD, READY)
//   pkt_rd_req_t      flat read request (req, addr) used by the wrapper when
//                     mapping the packet controller's request struct
// Also provides a fallback for the `PACKET_SIZE macro when the surrounding
// build has not defined it.
// -----------------------------------------------------------------------------
`ifndef PACKET_SIZE
`define PACKET_SIZE 32
`endif

package packet_sram_responder_pkg;

  localparam int PKT_SRAM_DEPTH  = 256;
  localparam int PKT_SRAM_ADDR_W = $clog2(PKT_SRAM_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    READY
  } pkt_sram_state_t;

  typedef struct packed {
    logic                       req;
    logic [PKT_SRAM_ADDR_W-1:0] addr;
  } pkt_rd_req_t;

endpackage

// File: rtl/packet_sram_array.sv
// -----------------------------------------------------------------------------
// packet_sram_array
// Behavioural single-write-port / single-synchronous-read-port storage array.
// Kept deliberately plain so it can be swapped for a compiled SRAM macro.
// Ports:
//   clk      clock
//   wr_en    write strobe, writes wr_data to wr_addr on the rising edge
//   wr_addr  write address
//   wr_data  write data (WIDTH bits, includes the parity bit when enabled)
//   rd_en    read strobe, captures mem[rd_addr] into rd_data on the edge
//   rd_addr  read address
//   rd_data  registered read data, holds its value while rd_en is low
// -----------------------------------------------------------------------------
module packet_sram_array
  import packet_sram_responder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = PKT_SRAM_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage has no reset, matching a real SRAM macro; the responder never
  // returns a slot that has not been written since the last load started.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/packet_sram_responder.sv
// -----------------------------------------------------------------------------
// packet_sram_responder
// Memory-side responder for the packet-fetch interface. A host load stream
// fills the packet array from address 0; once the final beat is written the
// responder serves one-cycle-latency packet reads to the packet controller.
// Ports:
//   clk, reset      single clock, asynchronous active-high reset
//   ld_start        pulse: (re)start a load at address 0
//   ld_valid/ld_data/ld_last/ld_ready   host load beat handshake
//   ld_done         pulse the cycle after the last beat is written
//   ld_ovf          sticky: beat offered while the array was full
//   rd_req/rd_addr  read request from the packet controller
//   rd_gnt          combinational grant
//   rd_valid/rd_data/rd_err  read response, one cycle after the grant
//   pkt_count       number of packets loaded
// Optional feature: define PACKET_SRAM_PARITY_EN to store an even-parity bit
// per slot and flag parity faults through rd_err.
// -----------------------------------------------------------------------------
`ifndef PACKET_SIZE
`define PACKET_SIZE 32
`endif

module packet_sram_responder
  import packet_sram_responder_pkg::*;
#(
  parameter int PACKET_W = `PACKET_SIZE,
  parameter int DEPTH    = PKT_SRAM_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ld_start,
  input  logic                ld_valid,
  input  logic [PACKET_W-1:0] ld_data,
  input  logic                ld_last,
  output logic                ld_ready,
  output logic                ld_done,
  output logic                ld_ovf,
  input  logic                rd_req,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic                rd_gnt,
  output logic                rd_valid,
  output logic [PACKET_W-1:0] rd_data,
  output logic                rd_err,
  output logic [ADDR_W:0]     pkt_count
);

`ifdef PACKET_SRAM_PARITY_EN
  localparam int MEM_W = PACKET_W + 1;
`else
  localparam int MEM_W = PACKET_W;
`endif

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

  pkt_sram_state_t state, state_next;

  logic [ADDR_W:0]  wr_ptr;
  logic             full;
  logic             ld_accept;
  logic             mem_wr_en;
  logic             rd_oor_q;
  logic             parity_fault;
  logic [MEM_W-1:0] mem_wr_data;
  logic [MEM_W-1:0] mem_rd_data;

  assign full      = (wr_ptr == FULL_COUNT);
  assign ld_accept = ld_valid & ld_ready;
  // A beat that coincides with ld_start belongs to the abandoned load.
  assign mem_wr_en = ld_accept & ~ld_start;
  assign pkt_count = wr_ptr;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: ld_start always wins and (re)enters LOAD from any state.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ld_start) state_next = LOAD;
      LOAD:    if (ld_start) state_next = LOAD;
               else if (ld_accept && ld_last) state_next = READY;
      READY:   if (ld_start) state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs: loads only while filling and not full, reads only
  // once a load has completed.
  always_comb begin
    ld_ready = 1'b0;
    rd_gnt   = 1'b0;
    case (state)
      LOAD:    ld_ready = ~full;
      READY:   rd_gnt   = rd_req;
      default: ;
    endcase
  end

  // Write pointer, load status flags and read response qualifiers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      ld_done  <= 1'b0;
      ld_ovf   <= 1'b0;
      rd_valid <= 1'b0;
      rd_oor_q <= 1'b0;
    end else begin
      ld_done  <= mem_wr_en & ld_last;
      rd_valid <= rd_gnt;
      rd_oor_q <= rd_gnt & ({1'b0, rd_addr} >= wr_ptr);
      if (ld_start) begin
        wr_ptr <= '0;
        ld_ovf <= 1'b0;
      end else begin
        if (ld_accept) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if ((state == LOAD) && full && ld_valid) begin
          ld_ovf <= 1'b1;
        end
      end
    end
  end

`ifdef PACKET_SRAM_PARITY_EN
  // Even parity: stored bit makes the XOR of the whole slot zero.
  assign mem_wr_data  = {^ld_data, ld_data};
  assign parity_fault = ^mem_rd_data;
`else
  assign mem_wr_data  = ld_data;
  assign parity_fault = 1'b0;
`endif

  packet_sram_array #(
    .WIDTH  (MEM_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .wr_en   (mem_wr_en),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_data (mem_wr_data),
    .rd_en   (rd_gnt),
    .rd_addr (rd_addr),
    .rd_data (mem_rd_data)
  );

  // The array output holds stale data between reads, so gate it to zero
  // unless a valid in-range response is being presented.
  assign rd_data = (rd_valid && !rd_oor_q) ? mem_rd_data[PACKET_W-1:0] : '0;
  assign rd_err  = rd_valid & (rd_oor_q | parity_fault);

endmodule

// File: tb/tb_packet_sram_responder.sv
// -----------------------------------------------------------------------------
// tb_packet_sram_responder
// Self-checking bench: a directed vector table for the basic load/read flow,
// hand-written sequences for overflow and mid-load reset, and randomized
// load/read traffic checked against a phase-level reference model.
// -----------------------------------------------------------------------------
`ifndef PACKET_SIZE
`define PACKET_SIZE 32
`endif

module tb_packet_sram_responder;

  localparam int PW    = `PACKET_SIZE;
  localparam int DEPTH = 256;
  localparam int AW    = $clog2(DEPTH);

  logic          clk;
  logic          reset;
  logic          ld_start;
  logic          ld_valid;
  logic [PW-1:0] ld_data;
  logic          ld_last;
  logic          ld_ready;
  logic          ld_done;
  logic          ld_ovf;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_gnt;
  logic          rd_valid;
  logic [PW-1:0] rd_data;
  logic          rd_err;
  logic [AW:0]   pkt_count;

  int n_cmp  = 0;
  int n_fail = 0;

  packet_sram_responder #(
    .PACKET_W (PW),
    .DEPTH    (DEPTH),
    .ADDR_W   (AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ld_start  (ld_start),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .ld_ready  (ld_ready),
    .ld_done   (ld_done),
    .ld_ovf    (ld_ovf),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_gnt    (rd_gnt),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_err    (rd_err),
    .pkt_count (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Directed vector record: inputs for one cycle and the outputs expected
  // just before the following rising edge.
  typedef struct {
    logic          st;
    logic          v;
    logic [PW-1:0] d;
    logic          last;
    logic          req;
    logic [AW-1:0] a;
    logic          e_ready;
    logic          e_done;
    logic          e_gnt;
    logic          e_valid;
    logic [PW-1:0] e_data;
    logic          e_err;
    logic [AW:0]   e_count;
  } vec_t;

  vec_t tbl[13];

  // Reference model state for the randomized section.
  logic [PW-1:0] m_mem [DEPTH];
  int            m_count;
  bit            m_loading;
  bit            m_serving;
  bit            m_done_pend;
  bit            p_valid;
  logic [PW-1:0] p_data;
  bit            p_err;

  function automatic vec_t mk(input logic st, input logic v, input logic [PW-1:0] d,
                              input logic last, input logic req, input logic [AW-1:0] a,
                              input logic e_ready, input logic e_done, input logic e_gnt,
                              input logic e_valid, input logic [PW-1:0] e_data,
                              input logic e_err, input logic [AW:0] e_count);
    vec_t r;
    r.st = st; r.v = v; r.d = d; r.last = last; r.req = req; r.a = a;
    r.e_ready = e_ready; r.e_done = e_done; r.e_gnt = e_gnt; r.e_valid = e_valid;
    r.e_data = e_data; r.e_err = e_err; r.e_count = e_count;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs after the falling edge, then settle so both
  // combinational and registered outputs can be sampled well before the
  // next rising edge.
  task automatic applyStimulus(input logic st, input logic v, input logic [PW-1:0] d,
                               input logic last, input logic req, input logic [AW-1:0] a);
    @(negedge clk);
    ld_start = st;
    ld_valid = v;
    ld_data  = d;
    ld_last  = last;
    rd_req   = req;
    rd_addr  = a;
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " ld_ready"},  ld_ready,  0);
    checkOutput({tag, " ld_done"},   ld_done,   0);
    checkOutput({tag, " ld_ovf"},    ld_ovf,    0);
    checkOutput({tag, " rd_gnt"},    rd_gnt,    0);
    checkOutput({tag, " rd_valid"},  rd_valid,  0);
    checkOutput({tag, " rd_data"},   rd_data,   0);
    checkOutput({tag, " rd_err"},    rd_err,    0);
    checkOutput({tag, " pkt_count"}, pkt_count, 0);
  endtask

  task automatic modelReset();
    m_count     = 0;
    m_loading   = 0;
    m_serving   = 0;
    m_done_pend = 0;
    p_valid     = 0;
    p_data      = '0;
    p_err       = 0;
  endtask

  // One randomized cycle: compare against the model's view of this cycle,
  // then advance the model by the effect of the coming clock edge.
  task automatic doStep(input logic st, input logic v, input logic [PW-1:0] d,
                        input logic last, input logic req, input logic [AW-1:0] a);
    applyStimulus(st, v, d, last, req, a);
    checkOutput("rnd rd_gnt",    rd_gnt,    64'(m_serving && req));
    checkOutput("rnd rd_valid",  rd_valid,  64'(p_valid));
    checkOutput("rnd rd_data",   rd_data,   64'(p_data));
    checkOutput("rnd rd_err",    rd_err,    64'(p_err));
    checkOutput("rnd ld_done",   ld_done,   64'(m_done_pend));
    checkOutput("rnd ld_ready",  ld_ready,  64'(m_loading && (m_count < DEPTH)));
    checkOutput("rnd pkt_count", pkt_count, 64'(m_count));
    checkOutput("rnd ld_ovf",    ld_ovf,    0);
    p_valid     = m_serving && req;
    p_err       = p_valid && (int'(a) >= m_count);
    p_data      = (p_valid && (int'(a) < m_count)) ? m_mem[a] : '0;
    m_done_pend = 0;
    if (st) begin
      m_loading = 1;
      m_serving = 0;
      m_count   = 0;
    end else if (m_loading && v && (m_count < DEPTH)) begin
      m_mem[m_count] = d;
      m_count++;
      if (last) begin
        m_loading   = 0;
        m_serving   = 1;
        m_done_pend = 1;
      end
    end
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    ld_start = 1'b0;
    ld_valid = 1'b0;
    ld_data  = '0;
    ld_last  = 1'b0;
    rd_req   = 1'b0;
    rd_addr  = '0;

    // Reset state, both during and just after reset.
    #12;
    checkAllZero("reset");
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkAllZero("post-reset");

    // Basic load of 0xA0..0xA3 with a read held during LOAD, then reads.
    tbl[0]  = mk(1, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0,    0, 0);
    tbl[1]  = mk(0, 1, 'hA0, 0, 1, 0, 1, 0, 0, 0, 0,    0, 0);
    tbl[2]  = mk(0, 1, 'hA1, 0, 1, 0, 1, 0, 0, 0, 0,    0, 1);
    tbl[3]  = mk(0, 1, 'hA2, 0, 1, 0, 1, 0, 0, 0, 0,    0, 2);
    tbl[4]  = mk(0, 1, 'hA3, 1, 1, 0, 1, 0, 0, 0, 0,    0, 3);
    tbl[5]  = mk(0, 0, 0,    0, 1, 0, 0, 1, 1, 0, 0,    0, 4);
    tbl[6]  = mk(0, 0, 0,    0, 1, 1, 0, 0, 1, 1, 'hA0, 0, 4);
    tbl[7]  = mk(0, 0, 0,    0, 1, 2, 0, 0, 1, 1, 'hA1, 0, 4);
    tbl[8]  = mk(0, 0, 0,    0, 1, 3, 0, 0, 1, 1, 'hA2, 0, 4);
    tbl[9]  = mk(0, 0, 0,    0, 1, 7, 0, 0, 1, 1, 'hA3, 0, 4);
    tbl[10] = mk(0, 0, 0,    0, 0, 0, 0, 0, 0, 1, 0,    1, 4);
    tbl[11] = mk(0, 1, 'h55, 0, 0, 0, 0, 0, 0, 0, 0,    0, 4);
    tbl[12] = mk(0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0,    0, 4);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(tbl[i].st, tbl[i].v, tbl[i].d, tbl[i].last, tbl[i].req, tbl[i].a);
      checkOutput($sformatf("vec%0d ld_ready", i),  ld_ready,  tbl[i].e_ready);
      checkOutput($sformatf("vec%0d ld_done", i),   ld_done,   tbl[i].e_done);
      checkOutput($sformatf("vec%0d rd_gnt", i),    rd_gnt,    tbl[i].e_gnt);
      checkOutput($sformatf("vec%0d rd_valid", i),  rd_valid,  tbl[i].e_valid);
      checkOutput($sformatf("vec%0d rd_data", i),   rd_data,   tbl[i].e_data);
      checkOutput($sformatf("vec%0d rd_err", i),    rd_err,    tbl[i].e_err);
      checkOutput($sformatf("vec%0d pkt_count", i), pkt_count, tbl[i].e_count);
      checkOutput($sformatf("vec%0d ld_ovf", i),    ld_ovf,    0);
    end

    // Fill the whole array with no ld_last and keep offering beats.
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(0, 1, PW'(i), 0, 0, 0);
      checkOutput("fill ld_ready", ld_ready, 1);
    end
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("full ld_ready",  ld_ready,  0);
    checkOutput("full pkt_count", pkt_count, DEPTH);
    checkOutput("full ld_ovf",    ld_ovf,    0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("ovf set",        ld_ovf,    1);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("ovf sticky",     ld_ovf,    1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("restart ld_ovf",    ld_ovf,    0);
    checkOutput("restart pkt_count", pkt_count, 0);
    checkOutput("restart ld_ready",  ld_ready,  1);

    // Asynchronous reset after two beats of a load.
    applyStimulus(0, 1, 'hB0, 0, 0, 0);
    applyStimulus(0, 1, 'hB1, 0, 0, 0);
    applyStimulus(0, 1, 'hB2, 0, 1, 0);
    checkOutput("midload pkt_count", pkt_count, 2);
    checkOutput("midload ld_ready",  ld_ready,  1);
    #1;
    reset = 1'b1;
    #1;
    checkAllZero("async reset");
    @(negedge clk);
    reset    = 1'b0;
    ld_valid = 1'b0;
    rd_req   = 1'b0;
    #1;
    checkAllZero("after async reset");

    // Randomized loads and reads; each new load's ld_start carries a random
    // read so a read granted alongside ld_start is also exercised.
    modelReset();
    for (int iter = 0; iter < 8; iter++) begin
      int n;
      int k;
      int budget;
      n = $urandom_range(1, 24);
      doStep(1, 0, 0, 0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)));
      k = 0;
      budget = 0;
      while (k < n && budget < 200) begin
        bit v;
        v = ($urandom_range(0, 3) != 0);
        doStep(0, v, PW'($urandom), (k == n - 1), 1'($urandom_range(0, 1)),
               AW'($urandom_range(0, 31)));
        if (v) k++;
        budget++;
      end
      for (int j = 0; j < 10; j++) begin
        doStep(0, 0, 0, 0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, n + 7)));
      end
    end
    doStep(0, 0, 0, 0, 0, 0);

`ifdef PACKET_SRAM_PARITY_EN
    // Corrupt the stored parity of slot 1 and read it back.
    doStep(1, 0, 0,    0, 0, 0);
    doStep(0, 1, 'hA0, 0, 0, 0);
    doStep(0, 1, 'hA1, 0, 0, 0);
    doStep(0, 1, 'hA2, 0, 0, 0);
    doStep(0, 1, 'hA3, 1, 0, 0);
    doStep(0, 0, 0,    0, 0, 0);
    dut.u_array.mem[1][PW] = ~dut.u_array.mem[1][PW];
    applyStimulus(0, 0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("parity rd_valid", rd_valid, 1);
    checkOutput("parity rd_err",   rd_err,   1);
    checkOutput("parity rd_data",  rd_data,  'hA1);
`endif

    $display("[TB] done");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/packet_sram_responder.md
# packet_sram_responder

Memory-side responder for the packet-fetch interface. The packet controller issues read requests to it for instruction packets. It owns the packet SRAM array, accepts a host load stream that fills the array before a run, and then serves single-cycle-issue, one-cycle-latency packet reads. It sits between the host/DMA loader and the packet controller's `PACKET_CNTL2SRAM` / `Data_SRAM_in` pair; the integration level maps struct fields onto the flat ports below.

## Interface
- `PACKET_W`, default `` `packet_size ``: packet width in bits.
- `DEPTH`, default 256: packet slots, power of two.
- `ADDR_W`, default `$clog2(DEPTH)`: address width.
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high reset.
- `ld_start`  in  1  one-cycle pulse; begins a new load at address 0.
- `ld_valid`  in  1  host beat valid.
- `ld_data`  in  PACKET_W  packet to write.
- `ld_last`  in  1  marks the final packet of the load.
- `ld_ready`  out  1  beat accepted when `ld_valid & ld_ready`.
- `ld_done`  out  1  one-cycle pulse after the last beat is written.
- `ld_ovf`  out  1  sticky; `ld_valid` seen while the array is full.
- `rd_req`  in  1  packet read request from the packet controller.
- `rd_addr`  in  ADDR_W  packet index.
- `rd_gnt`  out  1  combinational; request accepted this cycle.
- `rd_valid`  out  1  `rd_data` valid.
- `rd_data`  out  PACKET_W  packet returned (drives `Data_SRAM_in`).
- `rd_err`  out  1  qualifies `rd_valid`; address not loaded, or parity fault.
- `pkt_count`  out  ADDR_W+1  packets loaded.

## Operation
- FSM states: IDLE, LOAD, READY. Reset → IDLE.
- IDLE: `ld_ready=0`, `rd_gnt=0`. `ld_start` → LOAD, with `wr_ptr=0` and `pkt_count=0`.
- LOAD:
  - `ld_ready = (wr_ptr != DEPTH)`.
  - Each accepted beat writes `mem[wr_ptr]` and increments `wr_ptr` and `pkt_count`.
  - An accepted beat with `ld_last` → READY, and `ld_done` pulses next cycle.
  - Reads are never granted in LOAD (`rd_gnt=0`); the requester holds `rd_req`.
- READY:
  - `rd_gnt = rd_req`.
  - A granted read returns `mem[rd_addr]`.
  - If `rd_addr >= pkt_count`, `rd_data=0` and `rd_err=1`.
  - `ld_valid` is ignored (`ld_ready=0`).
  - `ld_start` → LOAD. A read granted in the same cycle as `ld_start` still completes.
- `ld_start` while in LOAD restarts the load at address 0 and discards the partial count.
- Full array: `wr_ptr==DEPTH` forces `ld_ready=0`. `ld_valid` while full sets `ld_ovf`. `ld_ovf` clears only on reset or `ld_start`.
- Reset mid-load: all state returns to reset values. Array contents are undefined but unreachable, because `pkt_count=0`.

## Timing
- Reset values:
  - `ld_ready=0`, `ld_done=0`, `ld_ovf=0`.
  - `rd_gnt=0`, `rd_valid=0`, `rd_data=0`, `rd_err=0`.
  - `pkt_count=0`, FSM=IDLE.
- Read latency: granted at cycle N → `rd_valid`, `rd_data`, `rd_err` registered at N+1, held for exactly one cycle. `rd_data` returns to 0 when `rd_valid=0`.
- Back-to-back reads at one per cycle are supported in READY.
- Load throughput: one beat per cycle. The last beat at cycle N gives READY at N+1 and `ld_done` at N+1.
- Write-then-read hazard: none. Reads open only after the state transition.

## Configuration
- `PACKET_SRAM_PARITY_EN` defined:
  - Each slot stores an extra even-parity bit computed at write.
  - On a read, a mismatch sets `rd_err=1`; `rd_data` still carries the stored word.
  - Testbench force of a stored parity bit is permitted.
- Undefined: no parity storage; `rd_err` flags only out-of-range addresses.

## Structure
- The shared package holds:
  - `PKT_SRAM_DEPTH`.
  - An FSM enum `pkt_sram_state_t` {IDLE, LOAD, READY}.
  - A flat `pkt_rd_req_t` struct (req, addr), for use by the integration wrapper.
- Sub-module `packet_sram_array`: 1 write port and 1 synchronous read port. It is a behavioral array, replaceable by a compiled macro, and is `PACKET_W(+1)` wide under parity.
- FSM, pointers, range check and output registers live in the top module.

## Test plan
- Reset, then `ld_start`, then 4 beats (0xA0..0xA3, `ld_last` on the 4th) → `pkt_count=4`; `ld_done` pulses one cycle after beat 4.
- READY with `rd_req` at addresses 0,1,2,3 on consecutive cycles → `rd_valid` on 4 consecutive cycles with data 0xA0..0xA3, `rd_err=0`.
- `rd_req` at address 7 with `pkt_count=4` → `rd_data=0`, `rd_err=1`, one cycle later.
- Load `DEPTH` beats with no `ld_last`, keep `ld_valid` high → `ld_ready=0` at full; `ld_ovf=1`; a following `ld_start` clears `ld_ovf` and `pkt_count`.
- `rd_req` held during LOAD → `rd_gnt=0` until READY, then the first read is granted the cycle after `ld_last`. Assert `reset` mid-load (after beat 2) → all outputs return to reset values asynchronously.
- With `PACKET_SRAM_PARITY_EN`, flip the stored parity of slot 1 and read address 1 → `rd_err=1` and `rd_data=0xA1`.
